// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise divide ops complete as illegal.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       waddr_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       waddr_out,
  output logic             wr_en,
  output logic             dz,
  output logic             ill
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wr_en_q, wr_en_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic [4:0]         waddr_out_q, waddr_out_d;
  logic               dz_q, dz_d;
  logic               ill_q, ill_d;

  // Multiply step: conditional add of the multiplicand, then shift {carry, hi, lo} right.
  logic               signed_mul;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_nxt, mul_lo_nxt;
  logic [PW-1:0]      prod, prod_fix;

  assign signed_mul = (op == 2'b01);
  assign a_mag      = (signed_mul && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag      = (signed_mul && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {1'b0, WIDTH'(0)});
  assign mul_hi_nxt = mul_sum[WIDTH:1];
  assign mul_lo_nxt = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
  assign prod       = {mul_hi_nxt, mul_lo_nxt};
  assign prod_fix   = neg_q ? (~prod + PW'(1)) : prod;

`ifdef MULDIV_DIV_EN
  // Restoring divide step: acc_hi holds the partial remainder, acc_lo shifts dividend out and quotient in.
  logic               div_q, div_d;
  logic               remu_q, remu_d;
  logic [WIDTH:0]     rem_sh, div_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   div_hi_nxt, div_lo_nxt;

  assign rem_sh     = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff   = rem_sh - {1'b0, mcand_q};
  assign q_bit      = ~div_diff[WIDTH];
  assign div_hi_nxt = q_bit ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_lo_nxt = {acc_lo_q[WIDTH-2:0], q_bit};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    mcand_d     = mcand_q;
    neg_d       = neg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wr_en_d     = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    waddr_out_d = waddr_out_q;
    dz_d        = dz_q;
    ill_d       = ill_q;
`ifdef MULDIV_DIV_EN
    div_d       = div_q;
    remu_d      = remu_q;
`endif

    if (state_q == S_RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
`ifdef MULDIV_DIV_EN
      if (div_q) begin
        acc_hi_d = div_hi_nxt;
        acc_lo_d = div_lo_nxt;
      end else begin
        acc_hi_d = mul_hi_nxt;
        acc_lo_d = mul_lo_nxt;
      end
`else
      acc_hi_d = mul_hi_nxt;
      acc_lo_d = mul_lo_nxt;
`endif
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        wr_en_d = 1'b1;
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          result_d    = remu_q ? div_hi_nxt : div_lo_nxt;
          result_hi_d = remu_q ? div_lo_nxt : div_hi_nxt;
        end else begin
          {result_hi_d, result_d} = prod_fix;
        end
`else
        {result_hi_d, result_d} = prod_fix;
`endif
      end
    end else if (start) begin
      // Accept from IDLE, or from DONE so a held start re-issues right after completion.
      waddr_out_d = waddr_in;
      dz_d        = 1'b0;
      ill_d       = 1'b0;
      cnt_d       = '0;
      acc_hi_d    = '0;
      acc_lo_d    = a_mag;
      mcand_d     = b_mag;
      neg_d       = signed_mul && (a[WIDTH-1] ^ b[WIDTH-1]);
      state_d     = S_RUN;
      busy_d      = 1'b1;
`ifdef MULDIV_DIV_EN
      div_d       = op[1];
      remu_d      = op[0];
      if (op[1]) begin
        acc_lo_d = a;
        mcand_d  = b;
        neg_d    = 1'b0;
        if (b == '0) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          wr_en_d     = 1'b1;
          result_d    = '1;
          result_hi_d = a;
          dz_d        = 1'b1;
        end
      end
`else
      if (op[1]) begin
        state_d     = S_DONE;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        result_d    = '0;
        result_hi_d = '0;
        ill_d       = 1'b1;
      end
`endif
    end else begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      mcand_q     <= '0;
      neg_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      waddr_out_q <= '0;
      dz_q        <= 1'b0;
      ill_q       <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q       <= 1'b0;
      remu_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      mcand_q     <= mcand_d;
      neg_q       <= neg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      waddr_out_q <= waddr_out_d;
      dz_q        <= dz_d;
      ill_q       <= ill_d;
`ifdef MULDIV_DIV_EN
      div_q       <= div_d;
      remu_q      <= remu_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_en     = wr_en_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign waddr_out = waddr_out_q;
  assign dz        = dz_q;
  assign ill       = ill_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; divide checks follow the MULDIV_DIV_EN build setting.
module tb_mul_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic [4:0]   waddr_in;
  logic         busy, done, wr_en, dz, ill;
  logic [W-1:0] result, result_hi;
  logic [4:0]   waddr_out;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .waddr_in  (waddr_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .waddr_out (waddr_out),
    .wr_en     (wr_en),
    .dz        (dz),
    .ill       (ill)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for done (bounded); counts edges waited and cycles seen busy. Optionally scrambles operands.
  task automatic wait_done(input string tag, input bit scramble, output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && edges < 200) begin
      if (busy === 1'b1) busy_cycles++;
      if (scramble) begin
        a  = $urandom;
        b  = $urandom;
        op = 2'($urandom);
      end
      tick();
      edges++;
    end
    if (edges >= 200) check({tag, "_timeout"}, 64'(done), 64'(1));
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input logic [4:0] wa, input int exp_edges,
                        input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                        input logic exp_wr, input logic exp_dz, input logic exp_ill);
    int edges, bc;
    op = o; a = va; b = vb; waddr_in = wa; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(tag, 1'b0, edges, bc);
    check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
    check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_edges));
    check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    check({tag, "_wr_en"}, 64'(wr_en), 64'(exp_wr));
    check({tag, "_result"}, 64'(result), 64'(exp_lo));
    check({tag, "_result_hi"}, 64'(result_hi), 64'(exp_hi));
    check({tag, "_waddr_out"}, 64'(waddr_out), 64'(wa));
    check({tag, "_dz"}, 64'(dz), 64'(exp_dz));
    check({tag, "_ill"}, 64'(ill), 64'(exp_ill));
    tick();
    check({tag, "_done_pulse"}, 64'({done, wr_en}), 64'(0));
    check({tag, "_result_hold"}, {result_hi, result}, {exp_hi, exp_lo});
  endtask

  initial begin
    int edges, bc, pulses;

    // Reset, with start asserted to show reset wins.
    rst = 1'b1; start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5; waddr_in = 5'd1;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done_wr", 64'({done, wr_en}), 64'(0));
    check("rst_results", {result_hi, result}, 64'(0));
    check("rst_waddr_dz_ill", 64'({waddr_out, dz, ill}), 64'(0));
    rst = 1'b0; start = 1'b0;
    tick();

    // Abort a MULU mid-run with a 2-cycle reset.
    op = 2'b00; a = 32'd2; b = 32'd3; waddr_in = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_busy_after_accept", 64'(busy), 64'(1));
    check("abort_waddr_captured", 64'(waddr_out), 64'(3));
    repeat (5) tick();
    rst = 1'b1;
    tick();
    tick();
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_outputs", {result_hi, result}, 64'(0));
    check("abort_waddr_flags", 64'({waddr_out, dz, ill, done, wr_en}), 64'(0));
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1 || wr_en === 1'b1) pulses++;
    end
    check("abort_no_pulse", 64'(pulses), 64'(0));

    // Multiplies
    run_op("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32,
           32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    run_op("mulu_small", 2'b00, 32'd123, 32'd456, 5'd2, 32,
           32'h0000_DB18, 32'h0, 1'b1, 1'b0, 1'b0);
    run_op("mulu_carry", 2'b00, 32'h0001_0000, 32'h0001_0000, 5'd4, 32,
           32'h0, 32'h1, 1'b1, 1'b0, 1'b0);
    run_op("muls_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 5'd8, 32,
           32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("muls_minneg_x_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32,
           32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0);
    run_op("muls_minneg_x_5", 2'b01, 32'h8000_0000, 32'd5, 5'd10, 32,
           32'h8000_0000, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0);
    run_op("muls_both_neg", 2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 5'd11, 32,
           32'd6, 32'h0, 1'b1, 1'b0, 1'b0);

`ifdef MULDIV_DIV_EN
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 5'd12, 32, 32'd14, 32'd2, 1'b1, 1'b0, 1'b0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd13, 32, 32'd2, 32'd14, 1'b1, 1'b0, 1'b0);
    run_op("divu_max_1", 2'b10, 32'hFFFF_FFFF, 32'd1, 5'd14, 32,
           32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0);
    run_op("divu_small_big", 2'b10, 32'd5, 32'hFFFF_FFFF, 5'd15, 32,
           32'h0, 32'd5, 1'b1, 1'b0, 1'b0);
    run_op("divu_zero", 2'b10, 32'h1234, 32'h0, 5'd16, 0,
           32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b1, 1'b0);
    run_op("mulu_dz_clear", 2'b00, 32'd3, 32'd3, 5'd17, 32, 32'd9, 32'h0, 1'b1, 1'b0, 1'b0);
`else
    run_op("divu_zero_dis", 2'b10, 32'h1234, 32'h0, 5'd16, 0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    run_op("remu_dis", 2'b11, 32'd100, 32'd7, 5'd18, 0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    run_op("mulu_ill_clear", 2'b00, 32'd3, 32'd3, 5'd17, 32, 32'd9, 32'h0, 1'b1, 1'b0, 1'b0);
`endif

    // start held through RUN with operands changing every cycle.
    op = 2'b00; a = 32'd3; b = 32'd4; waddr_in = 5'd9; start = 1'b1;
    tick();
    wait_done("held", 1'b1, edges, bc);
    check("held_latency", 64'(edges), 64'(32));
    check("held_result", {result_hi, result}, 64'd12);
    check("held_waddr", 64'(waddr_out), 64'(9));
    op = 2'b00; a = 32'd6; b = 32'd7; waddr_in = 5'd10;
    tick();
    check("held_reaccept_busy", 64'(busy), 64'(1));
    check("held_reaccept_waddr", 64'(waddr_out), 64'(10));
    start = 1'b0;
    wait_done("held2", 1'b0, edges, bc);
    check("held2_latency", 64'(edges), 64'(32));
    check("held2_result", {result_hi, result}, 64'd42);
    tick();
    check("held2_idle", 64'({busy, done}), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
